// File: rtl/apb_master_bridge_p.sv
// Parametrised APB3/APB4 master bridge: single-shot requests become SETUP/ACCESS
// sequences on one of NUM_SLAVES decoded PSEL lines. Define APB_TIMEOUT_EN for the ACCESS wait-state limit.
module apb_master_bridge_p #(
  parameter int AW         = 9,
  parameter int DW         = 8,
  parameter int NUM_SLAVES = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic                     transfer,
  input  logic                     READ_WRITE,
  input  logic [AW-1:0]            apb_write_paddr,
  input  logic [DW-1:0]            apb_write_data,
  input  logic [DW/8-1:0]          apb_write_pstrb,
  input  logic [AW-1:0]            apb_read_paddr,
  output logic                     ready_out,
  output logic                     done,
  output logic [DW-1:0]            apb_read_data_out,
  output logic                     PSLVERR,
  output logic [AW-1:0]            PADDR,
  output logic [NUM_SLAVES-1:0]    PSEL,
  output logic                     PENABLE,
  output logic                     PWRITE,
  output logic [DW-1:0]            PWDATA,
  output logic [DW/8-1:0]          PSTRB,
  input  logic [NUM_SLAVES*DW-1:0] PRDATA_s,
  input  logic [NUM_SLAVES-1:0]    PREADY_s,
  input  logic [NUM_SLAVES-1:0]    PSLVERR_s
);

  localparam int SEL_BITS = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [SEL_BITS:0] NS_W = (SEL_BITS + 1)'(NUM_SLAVES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  state_t                  state_r;
  logic [SEL_BITS-1:0]     idx_r;
  logic [AW-1:0]           req_addr_s;
  logic [SEL_BITS-1:0]     req_idx_s;
  logic                    req_ok_s;
  logic [NUM_SLAVES-1:0]   psel_dec_s;
  logic                    sel_ready_s;
  logic                    sel_err_s;
  logic [DW-1:0]           sel_data_s;
  logic                    timeout_s;

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt_r;
  assign timeout_s = (wait_cnt_r == CW'(TIMEOUT));
`else
  // TIMEOUT >= 1, so without the wait counter this never fires and ACCESS waits for PREADY
  assign timeout_s = (TIMEOUT < 1);
`endif

  // Request address selection and slave index decode
  always_comb begin
    req_addr_s = READ_WRITE ? apb_write_paddr : apb_read_paddr;
    req_idx_s  = req_addr_s[AW-1 -: SEL_BITS];
    req_ok_s   = ({1'b0, req_idx_s} < NS_W);
  end

  // One-hot select for the new request and response mux from the latched slave
  always_comb begin
    psel_dec_s  = '0;
    sel_ready_s = 1'b0;
    sel_err_s   = 1'b0;
    sel_data_s  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      psel_dec_s[i] = (req_idx_s == SEL_BITS'(i));
      sel_ready_s   = sel_ready_s | ((idx_r == SEL_BITS'(i)) & PREADY_s[i]);
      sel_err_s     = sel_err_s | ((idx_r == SEL_BITS'(i)) & PSLVERR_s[i]);
      sel_data_s    = sel_data_s | ({DW{idx_r == SEL_BITS'(i)}} & PRDATA_s[i*DW +: DW]);
    end
  end

  // Transfer FSM with all bridge and APB outputs registered
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_r           <= ST_IDLE;
      idx_r             <= '0;
      ready_out         <= 1'b0;
      done              <= 1'b0;
      PSLVERR           <= 1'b0;
      apb_read_data_out <= '0;
      PADDR             <= '0;
      PSEL              <= '0;
      PENABLE           <= 1'b0;
      PWRITE            <= 1'b0;
      PWDATA            <= '0;
      PSTRB             <= '0;
`ifdef APB_TIMEOUT_EN
      wait_cnt_r        <= '0;
`endif
    end else begin
      done    <= 1'b0;
      PSLVERR <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          PSEL    <= '0;
          PENABLE <= 1'b0;
          if (ready_out && transfer) begin
            ready_out <= 1'b0;
            PWRITE    <= READ_WRITE;
            PADDR     <= req_addr_s;
            PWDATA    <= READ_WRITE ? apb_write_data : '0;
            PSTRB     <= READ_WRITE ? apb_write_pstrb : '0;
            if (req_ok_s) begin
              idx_r   <= req_idx_s;
              PSEL    <= psel_dec_s;
              state_r <= ST_SETUP;
            end else begin
              state_r <= ST_ERR;
            end
          end else begin
            ready_out <= 1'b1;
          end
        end
        ST_SETUP: begin
          PENABLE <= 1'b1;
          state_r <= ST_ACCESS;
`ifdef APB_TIMEOUT_EN
          wait_cnt_r <= '0;
`endif
        end
        ST_ACCESS: begin
          if (sel_ready_s) begin
            state_r   <= ST_IDLE;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            ready_out <= 1'b1;
            done      <= 1'b1;
            PSLVERR   <= sel_err_s;
            if (!PWRITE) begin
              apb_read_data_out <= sel_err_s ? '0 : sel_data_s;
            end else begin
              apb_read_data_out <= apb_read_data_out;
            end
          end else if (timeout_s) begin
            state_r           <= ST_IDLE;
            PSEL              <= '0;
            PENABLE           <= 1'b0;
            ready_out         <= 1'b1;
            done              <= 1'b1;
            PSLVERR           <= 1'b1;
            apb_read_data_out <= '0;
          end else begin
`ifdef APB_TIMEOUT_EN
            wait_cnt_r <= wait_cnt_r + CW'(1);
`endif
            state_r <= ST_ACCESS;
          end
        end
        ST_ERR: begin
          state_r           <= ST_IDLE;
          ready_out         <= 1'b1;
          done              <= 1'b1;
          PSLVERR           <= 1'b1;
          apb_read_data_out <= '0;
        end
        default: begin
          state_r   <= ST_IDLE;
          PSEL      <= '0;
          PENABLE   <= 1'b0;
          ready_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge_p.sv
// Scoreboard bench for apb_master_bridge_p with three slaves so the out-of-range decode path is reachable.
module tb_apb_master_bridge_p;

  localparam int AW = 9;
  localparam int DW = 8;
  localparam int SW = DW / 8;
  localparam int NS = 3;
  localparam int TO = 4;
  localparam int SB = 2;

  logic              PCLK = 1'b0;
  logic              PRESETn;
  logic              transfer;
  logic              READ_WRITE;
  logic [AW-1:0]     apb_write_paddr;
  logic [DW-1:0]     apb_write_data;
  logic [SW-1:0]     apb_write_pstrb;
  logic [AW-1:0]     apb_read_paddr;
  logic              ready_out;
  logic              done;
  logic [DW-1:0]     apb_read_data_out;
  logic              PSLVERR;
  logic [AW-1:0]     PADDR;
  logic [NS-1:0]     PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [DW-1:0]     PWDATA;
  logic [SW-1:0]     PSTRB;
  logic [NS*DW-1:0]  PRDATA_s;
  logic [NS-1:0]     PREADY_s;
  logic [NS-1:0]     PSLVERR_s;

  apb_master_bridge_p #(.AW(AW), .DW(DW), .NUM_SLAVES(NS), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .transfer(transfer), .READ_WRITE(READ_WRITE),
    .apb_write_paddr(apb_write_paddr), .apb_write_data(apb_write_data),
    .apb_write_pstrb(apb_write_pstrb), .apb_read_paddr(apb_read_paddr),
    .ready_out(ready_out), .done(done), .apb_read_data_out(apb_read_data_out),
    .PSLVERR(PSLVERR), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA_s(PRDATA_s), .PREADY_s(PREADY_s),
    .PSLVERR_s(PSLVERR_s)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [AW-1:0] addr;
    logic [NS-1:0] psel;
    logic          wr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
  } req_t;

  typedef struct {
    logic          err;
    logic [DW-1:0] rdata;
    int            cyc;
  } rsp_t;

  req_t          req_q[$];
  rsp_t          rsp_q[$];
  req_t          cur;
  rsp_t          r_mon;
  logic [DW-1:0] model_rdata;
  int            cyc = 0;
  int            n_vec = 0;
  int            n_err = 0;
  bit            mon_en = 1'b0;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: event with nothing expected (cycle %0d)", nm, cyc);
  endtask

  // Monitor: completion responses and APB phase contents against the scoreboard
  always @(negedge PCLK) begin
    if (mon_en) begin
      if (done === 1'b1) begin
        if (rsp_q.size() == 0) begin
          fail("unexpected_done");
        end else begin
          r_mon = rsp_q.pop_front();
          chk("pslverr", PSLVERR, r_mon.err);
          chk("rdata", apb_read_data_out, r_mon.rdata);
          chk("done_cycle", cyc, r_mon.cyc);
          chk("idle_sel_en", {PENABLE, PSEL}, '0);
        end
      end else begin
        chk("done_low", done, 1'b0);
        if (PSLVERR !== 1'b0) chk("pslverr_without_done", PSLVERR, 1'b0);
      end
      if (PSEL !== '0) begin
        if (PENABLE === 1'b0) begin
          if (req_q.size() == 0) fail("unexpected_psel");
          else cur = req_q.pop_front();
        end
        chk("psel", PSEL, cur.psel);
        chk("paddr", PADDR, cur.addr);
        chk("pwrite", PWRITE, cur.wr);
        chk("pwdata", PWDATA, cur.wdata);
        chk("pstrb", PSTRB, cur.strb);
      end
    end
  end

  task automatic noise();
    transfer        = 1'($urandom);
    READ_WRITE      = 1'($urandom);
    apb_write_paddr = AW'($urandom);
    apb_read_paddr  = AW'($urandom);
    apb_write_data  = DW'($urandom);
    apb_write_pstrb = SW'($urandom);
    PRDATA_s        = (NS*DW)'($urandom);
    PREADY_s        = NS'($urandom);
    PSLVERR_s       = NS'($urandom);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge PCLK);
      noise();
      transfer = 1'b0;
    end
  endtask

  // One request; slave lane idx answers after w wait cycles. rst_k >= 0 resets in that ACCESS cycle.
  task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                      input logic [SW-1:0] st, input logic [DW-1:0] rd, input logic err,
                      input int w, input int rst_k);
    int idx, t0, w_eff;
    logic abort;
    req_t q;
    rsp_t s;
    chk("ready_before_request", ready_out, 1'b1);
    transfer        = 1'b1;
    READ_WRITE      = wr;
    apb_write_paddr = wr ? addr : AW'($urandom);
    apb_read_paddr  = wr ? AW'($urandom) : addr;
    apb_write_data  = wd;
    apb_write_pstrb = st;
    idx   = int'(addr[AW-1 -: SB]);
    t0    = cyc;
    abort = 1'b0;
    w_eff = w;
`ifdef APB_TIMEOUT_EN
    if (w > TO) begin
      abort = 1'b1;
      w_eff = TO;
    end
`endif
    if (idx < NS) begin
      q.addr  = addr;
      q.psel  = '0;
      q.psel[idx] = 1'b1;
      q.wr    = wr;
      q.wdata = wr ? wd : '0;
      q.strb  = wr ? st : '0;
      req_q.push_back(q);
      s.cyc = t0 + 3 + w_eff;
    end else begin
      s.cyc = t0 + 2;
    end
    if (idx >= NS || abort) begin
      s.err   = 1'b1;
      s.rdata = '0;
    end else begin
      s.err   = err;
      s.rdata = wr ? model_rdata : (err ? '0 : rd);
    end
    if (rst_k < 0) begin
      rsp_q.push_back(s);
      model_rdata = s.rdata;
    end
    @(negedge PCLK);
    noise();
    if (idx < NS) begin
      for (int k = 0; k <= w_eff; k++) begin
        @(negedge PCLK);
        noise();
        if (k == rst_k) begin
          PRESETn       = 1'b0;
          transfer      = 1'b1;
          PREADY_s[idx] = 1'b0;
          @(negedge PCLK);
          transfer = 1'b1;
          chk("rst_psel", PSEL, '0);
          chk("rst_penable", PENABLE, 1'b0);
          chk("rst_done", done, 1'b0);
          chk("rst_ready", ready_out, 1'b0);
          chk("rst_rdata", apb_read_data_out, '0);
          PRESETn = 1'b1;
          @(negedge PCLK);
          chk("ready_after_release", ready_out, 1'b1);
          chk("psel_after_release", PSEL, '0);
          transfer    = 1'b0;
          model_rdata = '0;
          return;
        end
        PREADY_s[idx] = (k == w_eff) && !abort;
        if (k == w_eff) begin
          PSLVERR_s[idx]          = err;
          PRDATA_s[idx*DW +: DW]  = rd;
        end
      end
    end
    @(negedge PCLK);
    transfer = 1'b0;
  endtask

  logic          r_wr, r_err;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wd, r_rd;
  logic [SW-1:0] r_st;

  initial begin
    PRESETn = 1'b0;
    noise();
    transfer    = 1'b1;
    model_rdata = '0;
    repeat (3) @(negedge PCLK);
    chk("reset_ready", ready_out, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_pslverr", PSLVERR, 1'b0);
    chk("reset_psel", PSEL, '0);
    chk("reset_penable", PENABLE, 1'b0);
    chk("reset_pwrite", PWRITE, 1'b0);
    chk("reset_paddr", PADDR, '0);
    chk("reset_pwdata", PWDATA, '0);
    chk("reset_pstrb", PSTRB, '0);
    chk("reset_rdata", apb_read_data_out, '0);
    mon_en  = 1'b1;
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk("ready_first_edge", ready_out, 1'b1);
    transfer = 1'b0;
    idle(1);

    xfer(1'b1, 9'h0A5, 8'h3C, 1'b1, 8'h00, 1'b0, 0, -1);
    xfer(1'b0, 9'h0F0, 8'hFF, 1'b1, 8'h5A, 1'b0, 2, -1);
    xfer(1'b0, 9'h010, 8'h12, 1'b1, 8'hEE, 1'b1, 0, -1);
    xfer(1'b1, 9'h02A, 8'h77, 1'b1, 8'h99, 1'b0, 1, -1);
    xfer(1'b1, 9'h1C0, 8'h11, 1'b1, 8'h44, 1'b0, 0, -1);
    xfer(1'b0, 9'h005, 8'h00, 1'b0, 8'hC3, 1'b0, 100, -1);
    xfer(1'b0, 9'h005, 8'h00, 1'b0, 8'h96, 1'b0, TO, -1);
    idle(2);
    xfer(1'b0, 9'h0F0, 8'h00, 1'b0, 8'h21, 1'b0, 5, 1);
    xfer(1'b1, 9'h133, 8'hA7, 1'b1, 8'h00, 1'b0, 0, -1);

    for (int i = 0; i < 40; i++) begin
      r_wr   = 1'($urandom);
      r_addr = AW'($urandom);
      r_wd   = DW'($urandom);
      r_st   = SW'($urandom);
      r_rd   = DW'($urandom);
      r_err  = ($urandom_range(3, 0) == 0);
      xfer(r_wr, r_addr, r_wd, r_st, r_rd, r_err, int'($urandom_range(3, 0)), -1);
      if ($urandom_range(2, 0) == 0) idle(int'($urandom_range(2, 0)));
    end

    idle(3);
    chk("rsp_queue_drained", rsp_q.size(), 0);
    chk("req_queue_drained", req_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
